// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for wb_write_arbiter: ALU/LSU result handshakes, register-file write port, status.
// WB_COMMIT_TRACE_EN adds per-entry pc inputs and the registered commit-trace outputs.
interface wb_write_arbiter_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     pending_mask;
  logic [63:0]     commit_cnt;
`ifdef WB_COMMIT_TRACE_EN
  logic [63:0]     alu_pc;
  logic [63:0]     lsu_pc;
  logic            trace_valid;
  logic [63:0]     trace_pc;
  logic [4:0]      trace_rd;
`endif

  modport slave (
`ifdef WB_COMMIT_TRACE_EN
    input  alu_pc, lsu_pc,
    output trace_valid, trace_pc, trace_rd,
`endif
    input  flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, pending_mask, commit_cnt
  );

  modport master (
`ifdef WB_COMMIT_TRACE_EN
    output alu_pc, lsu_pc,
    input  trace_valid, trace_pc, trace_rd,
`endif
    output flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, rf_we, rf_waddr, rf_wdata, pending_mask, commit_cnt
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: two per-source FIFOs, round-robin grant, one registered RF write per cycle.
// Optional WB_COMMIT_TRACE_EN stores pc per entry and drives trace_valid/trace_pc/trace_rd.
module wb_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic                clk,
  input  logic                rst,
  wb_write_arbiter_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
`ifdef WB_COMMIT_TRACE_EN
    logic [63:0]     pc;
`endif
  } entry_t;

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  // Index 0 is the ALU source, index 1 the LSU source.
  entry_t          mem_q    [2][DEPTH];
  logic [PW-1:0]   wr_ptr_q [2];
  logic [PW-1:0]   rd_ptr_q [2];
  logic [CW-1:0]   cnt_q    [2];
  entry_t          in_entry [2];
  entry_t          head     [2];
  logic [1:0]      in_valid;
  logic [1:0]      ready;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      not_empty;

  grant_e          last_grant_q, last_grant_d;
  grant_e          grant_sel;
  logic            grant_any;
  entry_t          grant_entry;

  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [63:0]     commit_cnt_q;
  logic [31:0]     pending;

  always_comb begin
    in_valid          = {bus.lsu_valid, bus.alu_valid};
    in_entry[0].rd    = bus.alu_rd;
    in_entry[0].data  = bus.alu_data;
    in_entry[1].rd    = bus.lsu_rd;
    in_entry[1].data  = bus.lsu_data;
`ifdef WB_COMMIT_TRACE_EN
    in_entry[0].pc    = bus.alu_pc;
    in_entry[1].pc    = bus.lsu_pc;
`endif
    for (int s = 0; s < 2; s++) begin
      // Ready looks only at the count, so a full FIFO refuses a push even while popping.
      ready[s]     = (cnt_q[s] != CW'(DEPTH)) & ~bus.flush;
      push[s]      = in_valid[s] & ready[s];
      not_empty[s] = (cnt_q[s] != '0);
      head[s]      = mem_q[s][rd_ptr_q[s]];
    end
  end

  // NOTE: FIFO storage has no reset; validity is tracked solely by the reset pointers/counts.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= in_entry[s];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (bus.flush) begin
          wr_ptr_q[s] <= '0;
          rd_ptr_q[s] <= '0;
          cnt_q[s]    <= '0;
        end else begin
          if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PW'(1);
          if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PW'(1);
          cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= GRANT_ALU;
    else     last_grant_q <= last_grant_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_any    = 1'b0;
    grant_sel    = GRANT_ALU;
    last_grant_d = last_grant_q;
    if (!bus.flush) begin
      if (not_empty[0] && not_empty[1]) begin
        grant_any = 1'b1;
        grant_sel = (last_grant_q == GRANT_ALU) ? GRANT_LSU : GRANT_ALU;
      end else if (not_empty[0]) begin
        grant_any = 1'b1;
        grant_sel = GRANT_ALU;
      end else if (not_empty[1]) begin
        grant_any = 1'b1;
        grant_sel = GRANT_LSU;
      end
    end
    if (grant_any) last_grant_d = grant_sel;
    pop[0]      = grant_any && (grant_sel == GRANT_ALU);
    pop[1]      = grant_any && (grant_sel == GRANT_LSU);
    grant_entry = (grant_sel == GRANT_LSU) ? head[1] : head[0];
  end

  // NOTE: registered state uses non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      // x0 grants retire and count but never write the register file.
      rf_we_q      <= grant_any && (grant_entry.rd != 5'd0);
      commit_cnt_q <= commit_cnt_q + 64'(grant_any);
      if (grant_any) begin
        rf_waddr_q <= grant_entry.rd;
        rf_wdata_q <= grant_entry.data;
      end
    end
  end

`ifdef WB_COMMIT_TRACE_EN
  logic        trace_valid_q;
  logic [63:0] trace_pc_q;
  logic [4:0]  trace_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_rd_q    <= '0;
    end else begin
      trace_valid_q <= grant_any;
      if (grant_any) begin
        trace_pc_q <= grant_entry.pc;
        trace_rd_q <= grant_entry.rd;
      end
    end
  end

  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_pc    = trace_pc_q;
  assign bus.trace_rd    = trace_rd_q;
`endif

  always_comb begin
    pending = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < cnt_q[s]) pending[mem_q[s][rd_ptr_q[s] + PW'(i)].rd] = 1'b1;
      end
    end
    if (rf_we_q) pending[rf_waddr_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign bus.alu_ready    = ready[0];
  assign bus.lsu_ready    = ready[1];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pending_mask = pending;
  assign bus.commit_cnt   = commit_cnt_q;
endmodule
